bcd_display_scanner: RTL and testbench
======================================

// Module: bcd_display_scanner
// PURPOSE
//   Downstream consumer of the BinaryToDecimal ROM stage. Captures a 16-bit packed BCD word
//   (4 nibbles, ones in [3:0]) and time-multiplexes it onto the Basys3 4-digit common-anode
//   7-segment display. Includes a refresh prescaler, a digit scan counter, leading-zero
//   blanking and a dash glyph for invalid nibbles. All display outputs are registered.
// PARAMETERS
//   CLK_DIV        100000  clock cycles per digit slot (1 kHz/digit at 100 MHz); legal >=1
//   BLANK_LEADING  1       1 = blank leading-zero digits 3..1; 0 = always show all digits
// PORTS
//   Clk     in   1   system clock, rising edge
//   Reset   in   1   asynchronous, active-high reset
//   BcdIn   in   16  packed BCD word; nibble k drives digit k (k=0 is rightmost)
//   Load    in   1   when 1 at a Clk edge, BcdIn is captured into DispReg
//   Seg     out  7   segment drive {g,f,e,d,c,b,a}, active-low
//   Dp      out  1   decimal point, active-low; always 1 (off)
//   An      out  4   anode enables, active-low; An[k] selects digit k
// BEHAVIOUR
//   Reset (async, dominates all inputs): DispReg=16'h0000, PreCnt=0, DigitIdx=0,
//     An=4'b1111, Seg=7'b1111111, Dp=1. Applied immediately, with no clock edge required.
//   Prescaler: PreCnt counts 0..CLK_DIV-1 and wraps to 0. Tick=1 when PreCnt==CLK_DIV-1.
//     With CLK_DIV=1, Tick=1 on every cycle.
//   Scan: DigitIdx advances 0->1->2->3->0 on each edge where Tick=1. Each digit is
//     displayed for exactly CLK_DIV cycles.
//   Output regs: on every edge, An <= ~(4'b0001<<DigitIdx) and Seg <= glyph(DispReg nibble
//     DigitIdx). These outputs lag DigitIdx by 1 cycle. The first edge after Reset is
//     released gives An=4'b1110 and Seg=glyph(0)=7'b1000000.
//   Load: DispReg <= BcdIn on an edge with Load=1. The new value appears on Seg at the
//     following edge (2 edges from the Load edge) if its digit is the active one.
//     Load does not disturb PreCnt, DigitIdx or An.
//   Glyphs (active-low gfedcba):
//     0=1000000  1=1111001  2=0100100  3=0110000  4=0011001
//     5=0010010  6=0000010  7=1111000  8=0000000  9=0010000
//     Nibble A..F renders as a dash, 7'b0111111.
//   Blanking (BLANK_LEADING=1): digit k (k=1..3) has Seg=7'b1111111 when nibbles k..3 are
//     all 4'h0. The anode stays asserted. Digit 0 is never blanked. Invalid nibbles count
//     as non-zero for blanking.
//   Boundaries:
//     DispReg=0 shows a single '0'.
//     Nibbles 0 below a non-zero higher nibble are shown as '0' (e.g. 16'h0105).
//     Reset during a scan returns to digit 0 with PreCnt=0 and clears DispReg.
//     Load coinciding with a Tick: both take effect on that edge.
// TESTING (CLK_DIV=4, BLANK_LEADING=1, CLK_PERIOD=2)
//   1. Assert Reset mid-run with no clock edge -> An=1111, Seg=1111111 and Dp=1 at once.
//      Release -> next edge An=1110, Seg=1000000; DigitIdx advances every 4 cycles.
//   2. Load 16'h0063 -> over 16 cycles: An=1110 Seg=0110000; An=1101 Seg=0000010;
//      An=1011 and An=0111 both Seg=1111111 (blanked).
//   3. Load 16'h1A05 -> digit0 0010010, digit1 1000000, digit2 0111111 (dash),
//      digit3 1111001.
//   4. Load 16'h0009 while An=1110 shows '3' -> Seg=0010000 exactly 2 edges later;
//      An and the scan phase are unchanged.
//   5. Reset asserted while DigitIdx=2 -> outputs reset asynchronously. After release:
//      digit 0 shows '0', digits 1..3 are blank, and the scan period is again 4 cycles/digit.
//   6. Sweep i=0..63 loading {i/10,i%10} (the ROM output format) -> digit0 = glyph(i%10);
//      digit1 = glyph(i/10), blank when i<10; digits 2..3 blank. Report pass/fail summary.

Source files
------------

// File: rtl/bcd_display_scanner.sv
`timescale 1ns/100ps
`default_nettype none
// ============================================================================
// Module  : bcd_display_scanner
// Brief   : Scans a captured 4-digit packed BCD word onto a common-anode
//           7-segment display with leading-zero blanking and a dash glyph.
// Revision: 1.0 - initial release
// ============================================================================
module bcd_display_scanner #(
    parameter int CLK_DIV       = 100000,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [15:0] BcdIn,
    input  logic        Load,
    output logic [6:0]  Seg,
    output logic        Dp,
    output logic [3:0]  An
);

    localparam int                 c_CNT_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX   = c_CNT_W'(CLK_DIV - 1);
    localparam logic [6:0]         c_SEG_BLANK = 7'b1111111;
    localparam logic [6:0]         c_SEG_DASH  = 7'b0111111;

    logic [15:0]        r_disp;
    logic [c_CNT_W-1:0] r_pre_cnt;
    logic [1:0]         r_digit_idx;

    logic               w_tick;
    logic [3:0]         w_nib_zero;
    logic [3:0]         w_lead_zero;
    logic [3:0]         w_nibble;
    logic               w_blank;
    logic [6:0]         w_glyph;

    assign w_tick = (r_pre_cnt == c_CNT_MAX);

    generate
        for (genvar k = 0; k < 4; k++) begin : g_nib_zero
            assign w_nib_zero[k] = (r_disp[4*k +: 4] == 4'h0);
        end
    endgenerate

    // w_lead_zero[k] is set when nibbles k..3 are all zero
    assign w_lead_zero[3] = w_nib_zero[3];
    assign w_lead_zero[2] = w_nib_zero[2] & w_lead_zero[3];
    assign w_lead_zero[1] = w_nib_zero[1] & w_lead_zero[2];
    assign w_lead_zero[0] = w_nib_zero[0] & w_lead_zero[1];

    assign w_nibble = r_disp[{r_digit_idx, 2'b00} +: 4];
    assign w_blank  = BLANK_LEADING && (r_digit_idx != 2'd0) && w_lead_zero[r_digit_idx];

    always_comb begin
        w_glyph = c_SEG_DASH;
        case (w_nibble)
            4'h0:    w_glyph = 7'b1000000;
            4'h1:    w_glyph = 7'b1111001;
            4'h2:    w_glyph = 7'b0100100;
            4'h3:    w_glyph = 7'b0110000;
            4'h4:    w_glyph = 7'b0011001;
            4'h5:    w_glyph = 7'b0010010;
            4'h6:    w_glyph = 7'b0000010;
            4'h7:    w_glyph = 7'b1111000;
            4'h8:    w_glyph = 7'b0000000;
            4'h9:    w_glyph = 7'b0010000;
            default: w_glyph = c_SEG_DASH;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_pre_cnt   <= '0;
            r_digit_idx <= 2'd0;
        end else begin
            if (w_tick) begin
                r_pre_cnt   <= '0;
                r_digit_idx <= r_digit_idx + 2'd1;
            end else begin
                r_pre_cnt   <= r_pre_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_disp <= 16'h0000;
        end else if (Load) begin
            r_disp <= BcdIn;
        end
    end

    // Outputs are registered from the pre-edge digit index, so they trail it by one cycle
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            An  <= 4'b1111;
            Seg <= c_SEG_BLANK;
            Dp  <= 1'b1;
        end else begin
            An  <= ~(4'b0001 << r_digit_idx);
            Seg <= w_blank ? c_SEG_BLANK : w_glyph;
            Dp  <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bcd_display_scanner.sv
`timescale 1ns/100ps
`default_nettype none
// ============================================================================
// Module  : tb_bcd_display_scanner
// Brief   : Directed bench with a cycle-level display model and literal pins.
// Revision: 1.0 - initial release
// ============================================================================
module tb_bcd_display_scanner;

    localparam int CLK_DIV = 4;
    localparam logic [6:0] GLYPH [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
        7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111
    };

    logic        Clk   = 1'b0;
    logic        Reset = 1'b0;
    logic        Load  = 1'b0;
    logic [15:0] BcdIn = 16'h0000;
    logic [6:0]  Seg;
    logic        Dp;
    logic [3:0]  An;

    int checks   = 0;
    int failures = 0;
    int ecnt     = 0;

    logic        model_valid = 1'b0;
    int          edge_cnt    = 0;
    logic [15:0] model_disp  = 16'h0000;
    logic [3:0]  exp_an      = 4'hF;
    logic [6:0]  exp_seg     = 7'h7F;

    bcd_display_scanner #(
        .CLK_DIV       (CLK_DIV),
        .BLANK_LEADING (1'b1)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .BcdIn (BcdIn),
        .Load  (Load),
        .Seg   (Seg),
        .Dp    (Dp),
        .An    (An)
    );

    always #1 Clk = ~Clk;

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h at t=%0t", name, got, want, $time);
        end
    endtask

    // Digit shown after the (ec+1)-th edge since reset release
    function automatic logic [3:0] model_an(input int ec);
        int d;
        d = (ec / CLK_DIV) % 4;
        return ~(4'b0001 << d);
    endfunction

    function automatic logic [6:0] model_seg(input int ec, input logic [15:0] v);
        int          d;
        logic [15:0] upper;
        d     = (ec / CLK_DIV) % 4;
        upper = v >> (4 * d);
        if (d != 0 && upper == 16'h0000) return 7'h7F;
        return GLYPH[upper[3:0]];
    endfunction

    always @(posedge Reset) begin
        model_valid <= 1'b1;
        edge_cnt    <= 0;
        model_disp  <= 16'h0000;
        exp_an      <= 4'hF;
        exp_seg     <= 7'h7F;
    end

    always @(posedge Clk) begin
        if (!Reset) begin
            exp_an   <= model_an(edge_cnt);
            exp_seg  <= model_seg(edge_cnt, model_disp);
            edge_cnt <= edge_cnt + 1;
            if (Load) model_disp <= BcdIn;
        end
    end

    always @(negedge Clk) begin
        if (model_valid) begin
            check("model_an",  16'(An),  16'(exp_an));
            check("model_seg", 16'(Seg), 16'(exp_seg));
            check("model_dp",  16'(Dp),  16'h0001);
        end
    end

    task automatic run_to(input int e);
        while (ecnt < e) begin
            @(negedge Clk);
            ecnt++;
            Load = 1'b0;
        end
    endtask

    // Called at a negedge: async reset between edges, release at the next negedge
    task automatic restart(input logic ld, input logic [15:0] val);
        #0.5 Reset = 1'b1;
        #0.2;
        check("async_rst_an",  16'(An),  16'h000F);
        check("async_rst_seg", 16'(Seg), 16'h007F);
        check("async_rst_dp",  16'(Dp),  16'h0001);
        @(negedge Clk);
        Reset = 1'b0;
        Load  = ld;
        BcdIn = val;
        ecnt  = 0;
    endtask

    task automatic pin(input string name, input logic [3:0] an, input logic [6:0] seg);
        check({name, "_an"},  16'(An),  16'(an));
        check({name, "_seg"}, 16'(Seg), 16'(seg));
    endtask

    initial begin
        #0.5 Reset = 1'b1;
        #0.2;
        check("init_rst_an",  16'(An),  16'h000F);
        check("init_rst_seg", 16'(Seg), 16'h007F);
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        ecnt  = 0;
        run_to(1);  pin("t1_e1", 4'b1110, 7'b1000000);
        run_to(4);  pin("t1_e4", 4'b1110, 7'b1000000);
        run_to(5);  pin("t1_e5", 4'b1101, 7'b1111111);
        run_to(7);

        restart(1'b1, 16'h0063);
        run_to(1);  pin("t2_e1",  4'b1110, 7'b1000000);
        run_to(2);  pin("t2_e2",  4'b1110, 7'b0110000);
        run_to(5);  pin("t2_e5",  4'b1101, 7'b0000010);
        run_to(9);  pin("t2_e9",  4'b1011, 7'b1111111);
        run_to(13); pin("t2_e13", 4'b0111, 7'b1111111);
        run_to(17); pin("t2_e17", 4'b1110, 7'b0110000);

        restart(1'b1, 16'h1A05);
        run_to(2);  pin("t3_d0", 4'b1110, 7'b0010010);
        run_to(5);  pin("t3_d1", 4'b1101, 7'b1000000);
        run_to(9);  pin("t3_d2", 4'b1011, 7'b0111111);
        run_to(13); pin("t3_d3", 4'b0111, 7'b1111001);

        restart(1'b1, 16'h0063);
        run_to(2);  pin("t4_pre", 4'b1110, 7'b0110000);
        Load  = 1'b1;
        BcdIn = 16'h0009;
        run_to(3);  pin("t4_ld_edge", 4'b1110, 7'b0110000);
        run_to(4);  pin("t4_ld_p1",   4'b1110, 7'b0010000);
        run_to(5);  pin("t4_phase",   4'b1101, 7'b1111111);
        run_to(6);

        restart(1'b1, 16'h0063);
        run_to(10); pin("t5_d2", 4'b1011, 7'b1111111);
        restart(1'b0, 16'h0000);
        run_to(1);  pin("t5_e1",  4'b1110, 7'b1000000);
        run_to(4);  pin("t5_e4",  4'b1110, 7'b1000000);
        run_to(5);  pin("t5_e5",  4'b1101, 7'b1111111);
        run_to(9);  pin("t5_e9",  4'b1011, 7'b1111111);
        run_to(13); pin("t5_e13", 4'b0111, 7'b1111111);
        run_to(17); pin("t5_e17", 4'b1110, 7'b1000000);

        for (int i = 0; i < 64; i++) begin
            restart(1'b1, {8'h00, 4'(i / 10), 4'(i % 10)});
            run_to(2);  pin("t6_d0", 4'b1110, GLYPH[i % 10]);
            run_to(5);  pin("t6_d1", 4'b1101, (i < 10) ? 7'h7F : GLYPH[i / 10]);
            run_to(9);  pin("t6_d2", 4'b1011, 7'h7F);
            run_to(13); pin("t6_d3", 4'b0111, 7'h7F);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
